raytracing_scheduler: RTL and testbench

Frame-level controller that sequences the bank of raytracing workers row by row. For each screen row it:
- computes the row-constant terms (pixel_y², dot-y, sphere_y²) shared by all workers;
- activates the workers and waits for every worker to finish;
- streams the finished row's colors to the framebuffer writer in ascending x order over a valid/ready handshake.

It sits between the frame timing/scene logic and the worker array.

---
 rtl/raytracing_scheduler_pkg.sv | 48 ++++
 rtl/raytracing_scheduler_if.sv | 26 ++
 rtl/raytracing_row_setup.sv | 60 ++++++
 rtl/raytracing_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_raytracing_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/raytracing_scheduler_pkg.sv
// Shared types and widths for the raytracing scheduler slice.
package raytracing_scheduler_pkg;

    localparam int unsigned COORD_W     = 12;
    localparam int unsigned CHAN_W      = 8;
    localparam int unsigned FP_B        = 4;
    localparam int unsigned PX_Y_W      = 10;
    localparam int unsigned PX_Y_SQRD_B = 17;
    localparam int unsigned DOTY_W      = 22;
    localparam int unsigned S_Y_SQRD_B  = 2 * COORD_W - FP_B;
    localparam int unsigned PIX_X_W     = 10;
    localparam int unsigned PIX_Y_W     = 9;
    localparam int unsigned START_X_W   = 12;
    localparam int unsigned WD_W        = 16;

    localparam int unsigned DEF_N_WORKERS = 8;
    localparam int unsigned DEF_JOBS      = 80;
    localparam int unsigned H_RES         = DEF_N_WORKERS * DEF_JOBS;
    localparam int unsigned V_RES         = 480;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
        logic        [15:0]        r_sqrd;
    } sphere_t;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } color_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVATE,
        S_WAIT_DONE,
        S_DRAIN,
        S_DONE
    } sched_state_e;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raytracing_scheduler_if.sv
// Pixel stream from the scheduler to the framebuffer writer (valid/ready).
interface raytracing_scheduler_if;

    logic                                      pix_valid;
    logic                                      pix_ready;
    logic [raytracing_scheduler_pkg::PIX_X_W-1:0] pix_x;
    logic [raytracing_scheduler_pkg::PIX_Y_W-1:0] pix_y;
    raytracing_scheduler_pkg::color_t          pix_color;

    modport master (
        output pix_valid,
        output pix_x,
        output pix_y,
        output pix_color,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        input  pix_color,
        output pix_ready
    );

endinterface

// File: rtl/raytracing_row_setup.sv
// Row-constant generator: registers pixel_y^2, pixel_y*sphere.y and
// (sphere.y^2)>>>FP_B one cycle after load.
module raytracing_row_setup
    import raytracing_scheduler_pkg::*;
#(
    parameter int unsigned V_RES = 480
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic                          load,
    input  logic [PIX_Y_W-1:0]            row,
    input  logic signed [COORD_W-1:0]     sphere_y,
    output logic [PX_Y_SQRD_B-1:0]        pixel_y_sqrd,
    output logic signed [DOTY_W-1:0]      doty,
    output logic signed [S_Y_SQRD_B-1:0]  sphere_y_sqrd
);

    logic signed [PX_Y_W-1:0]       pixel_y_c;
    logic signed [2*PX_Y_W-1:0]     py_sq_c;
    logic signed [DOTY_W-1:0]       doty_c;
    logic signed [2*COORD_W-1:0]    sy_sq_c;

    logic [PX_Y_SQRD_B-1:0]         pixel_y_sqrd_d, pixel_y_sqrd_q;
    logic signed [DOTY_W-1:0]       doty_d, doty_q;
    logic signed [S_Y_SQRD_B-1:0]   sphere_y_sqrd_d, sphere_y_sqrd_q;

    // Row arithmetic; pixel_y counts down from V_RES/2 at row 0.
    always_comb begin
        pixel_y_c       = $signed(PX_Y_W'(V_RES / 2)) - $signed({1'b0, row});
        py_sq_c         = pixel_y_c * pixel_y_c;
        doty_c          = pixel_y_c * sphere_y;
        sy_sq_c         = sphere_y * sphere_y;
        pixel_y_sqrd_d  = pixel_y_sqrd_q;
        doty_d          = doty_q;
        sphere_y_sqrd_d = sphere_y_sqrd_q;
        if (load) begin
            pixel_y_sqrd_d  = PX_Y_SQRD_B'($unsigned(py_sq_c));
            doty_d          = doty_c;
            sphere_y_sqrd_d = S_Y_SQRD_B'(sy_sq_c >>> FP_B);
        end
    end

    // Constants hold between loads.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            pixel_y_sqrd_q  <= '0;
            doty_q          <= '0;
            sphere_y_sqrd_q <= '0;
        end else begin
            pixel_y_sqrd_q  <= pixel_y_sqrd_d;
            doty_q          <= doty_d;
            sphere_y_sqrd_q <= sphere_y_sqrd_d;
        end
    end

    assign pixel_y_sqrd  = pixel_y_sqrd_q;
    assign doty          = doty_q;
    assign sphere_y_sqrd = sphere_y_sqrd_q;

endmodule

// File: rtl/raytracing_scheduler.sv
// Row-by-row frame controller for the raytracing worker bank.
// Optional build macro RT_SCHED_WATCHDOG_EN adds a stuck-worker watchdog
// and the sticky watchdog_err output.
module raytracing_scheduler
    import raytracing_scheduler_pkg::*;
#(
    parameter int unsigned N_WORKERS        = 8,
    parameter int unsigned JOBS_SUBDIVISION = 80,
    parameter int unsigned V_RES            = 480
) (
    input  logic                                          clk,
    input  logic                                          rst_,
    input  logic                                          frame_start,
    input  sphere_t                                       sphere,
    input  logic [N_WORKERS-1:0]                          worker_busy,
    input  color_t [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0]  worker_buffer,
    output logic                                          worker_activate,
    output logic [N_WORKERS-1:0][START_X_W-1:0]           worker_start_x,
    output logic signed [DOTY_W-1:0]                      doty,
    output logic [PX_Y_SQRD_B-1:0]                        pixel_y_sqrd,
    output logic signed [S_Y_SQRD_B-1:0]                  sphere_y_sqrd,
    output sphere_t                                       worker_sphere,
    raytracing_scheduler_if.master                        pix_if,
    output logic                                          busy,
    output logic                                          frame_done
`ifdef RT_SCHED_WATCHDOG_EN
    ,
    output logic                                          watchdog_err
`endif
);

    localparam int unsigned ROW_W  = N_WORKERS * JOBS_SUBDIVISION;
    localparam int unsigned W_BITS = idx_w(N_WORKERS);
    localparam int unsigned J_BITS = idx_w(JOBS_SUBDIVISION);

    sched_state_e                          state_d, state_q;
    logic [PIX_Y_W-1:0]                    row_d, row_q;
    logic [PIX_X_W-1:0]                    x_d, x_q;
    logic [W_BITS-1:0]                     w_d, w_q;
    logic [J_BITS-1:0]                     j_d, j_q;
    logic [N_WORKERS-1:0]                  seen_d, seen_q;
    sphere_t                               sphere_d, sphere_q;
    logic                                  activate_d, activate_q;
    logic                                  valid_d, valid_q;
    logic                                  busy_d, busy_q;
    logic                                  done_d, done_q;
    color_t                                color_d, color_q;
    logic [N_WORKERS-1:0][START_X_W-1:0]   start_x_d, start_x_q;

    logic                                  setup_load_c;
    logic                                  xfer_c;
    logic                                  x_last_c;
    logic                                  row_last_c;
    logic                                  w_wrap_c;
    logic [W_BITS-1:0]                     w_nxt_c;
    logic [J_BITS-1:0]                     j_nxt_c;

`ifdef RT_SCHED_WATCHDOG_EN
    logic [WD_W-1:0]                       wd_cnt_d, wd_cnt_q;
    logic                                  wd_err_d, wd_err_q;
    logic                                  wd_fire_c;
`endif

    // Row constants for the current row.
    raytracing_row_setup #(
        .V_RES (V_RES)
    ) u_row_setup (
        .clk           (clk),
        .rst_          (rst_),
        .load          (setup_load_c),
        .row           (row_q),
        .sphere_y      (sphere_q.y),
        .pixel_y_sqrd  (pixel_y_sqrd),
        .doty          (doty),
        .sphere_y_sqrd (sphere_y_sqrd)
    );

    // Per-worker first pixel column: -ROW_W/2 + w.
    always_comb begin
        start_x_d = '0;
        for (int w = 0; w < int'(N_WORKERS); w++) begin
            start_x_d[w] = START_X_W'(w) - START_X_W'(ROW_W / 2);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        x_d          = x_q;
        w_d          = w_q;
        j_d          = j_q;
        seen_d       = seen_q;
        sphere_d     = sphere_q;
        busy_d       = busy_q;
        color_d      = color_q;
        activate_d   = 1'b0;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        setup_load_c = 1'b0;

        xfer_c     = valid_q & pix_if.pix_ready;
        x_last_c   = (x_q == PIX_X_W'(ROW_W - 1));
        row_last_c = (row_q == PIX_Y_W'(V_RES - 1));
        w_wrap_c   = (w_q == W_BITS'(N_WORKERS - 1));
        w_nxt_c    = w_wrap_c ? '0 : w_q + W_BITS'(1);
        j_nxt_c    = w_wrap_c ? j_q + J_BITS'(1) : j_q;

`ifdef RT_SCHED_WATCHDOG_EN
        wd_cnt_d  = wd_cnt_q;
        wd_err_d  = wd_err_q;
        wd_fire_c = &wd_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    sphere_d = sphere;
                    row_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SETUP;
`ifdef RT_SCHED_WATCHDOG_EN
                    wd_err_d = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                setup_load_c = 1'b1;
                seen_d       = '0;
                x_d          = '0;
                w_d          = '0;
                j_d          = '0;
                activate_d   = 1'b1;
                state_d      = S_ACTIVATE;
`ifdef RT_SCHED_WATCHDOG_EN
                wd_cnt_d     = '0;
`endif
            end
            S_ACTIVATE: begin
                activate_d = 1'b1;
                seen_d     = seen_q | worker_busy;
                if (&seen_d) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (worker_busy == '0) begin
                    valid_d = 1'b1;
                    color_d = worker_buffer[0][0];
                    state_d = S_DRAIN;
                end else begin
                    activate_d = 1'b1;
                end
            end
            S_DRAIN: begin
                valid_d = 1'b1;
                if (xfer_c) begin
                    if (x_last_c) begin
                        valid_d = 1'b0;
                        if (row_last_c) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + PIX_Y_W'(1);
                            state_d = S_SETUP;
                        end
                    end else begin
                        x_d     = x_q + PIX_X_W'(1);
                        w_d     = w_nxt_c;
                        j_d     = j_nxt_c;
                        color_d = worker_buffer[w_nxt_c][j_nxt_c];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef RT_SCHED_WATCHDOG_EN
        // A worker that never finishes forces the row out of its current buffers.
        if ((state_q == S_ACTIVATE) || (state_q == S_WAIT_DONE)) begin
            if (wd_fire_c) begin
                activate_d = 1'b0;
                valid_d    = 1'b1;
                color_d    = worker_buffer[0][0];
                wd_err_d   = 1'b1;
                state_d    = S_DRAIN;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            x_q        <= '0;
            w_q        <= '0;
            j_q        <= '0;
            seen_q     <= '0;
            sphere_q   <= '0;
            activate_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            color_q    <= '0;
            start_x_q  <= start_x_d;
`ifdef RT_SCHED_WATCHDOG_EN
            wd_cnt_q   <= '0;
            wd_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            x_q        <= x_d;
            w_q        <= w_d;
            j_q        <= j_d;
            seen_q     <= seen_d;
            sphere_q   <= sphere_d;
            activate_q <= activate_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            color_q    <= color_d;
            start_x_q  <= start_x_d;
`ifdef RT_SCHED_WATCHDOG_EN
            wd_cnt_q   <= wd_cnt_d;
            wd_err_q   <= wd_err_d;
`endif
        end
    end

    assign worker_activate  = activate_q;
    assign worker_start_x   = start_x_q;
    assign worker_sphere    = sphere_q;
    assign busy             = busy_q;
    assign frame_done       = done_q;
    assign pix_if.pix_valid = valid_q;
    assign pix_if.pix_x     = x_q;
    assign pix_if.pix_y     = row_q;
    assign pix_if.pix_color = color_q;
`ifdef RT_SCHED_WATCHDOG_EN
    assign watchdog_err     = wd_err_q;
`endif

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Directed bench: 2 workers x 3 jobs, 2-row frame, plus a 480-row setup unit.
module tb_raytracing_scheduler;
    import raytracing_scheduler_pkg::*;

    logic                          clk;
    logic                          rst_;
    logic                          frame_start;
    sphere_t                       sphere;
    logic [1:0]                    worker_busy;
    color_t [1:0][2:0]             worker_buffer;
    logic                          worker_activate;
    logic [1:0][START_X_W-1:0]     worker_start_x;
    logic signed [DOTY_W-1:0]      doty;
    logic [PX_Y_SQRD_B-1:0]        pixel_y_sqrd;
    logic signed [S_Y_SQRD_B-1:0]  sphere_y_sqrd;
    sphere_t                       worker_sphere;
    logic                          busy;
    logic                          frame_done;
`ifdef RT_SCHED_WATCHDOG_EN
    logic                          watchdog_err;
`endif

    logic                          rs_load;
    logic [PIX_Y_W-1:0]            rs_row;
    logic signed [COORD_W-1:0]     rs_sphere_y;
    logic [PX_Y_SQRD_B-1:0]        rs_pixel_y_sqrd;
    logic signed [DOTY_W-1:0]      rs_doty;
    logic signed [S_Y_SQRD_B-1:0]  rs_sphere_y_sqrd;

    int checks = 0;
    int passed = 0;
    int xfers  = 0;
    int fd_count = 0;
    int exp_v [6] = '{0, 10, 1, 11, 2, 12};
    int wlat  [2] = '{2, 4};
    int wcnt  [2];
    bit wdone [2];
    sphere_t exp_sph;

    raytracing_scheduler_if pix_if ();

    raytracing_scheduler #(
        .N_WORKERS        (2),
        .JOBS_SUBDIVISION (3),
        .V_RES            (2)
    ) dut (
        .clk             (clk),
`ifdef RT_SCHED_WATCHDOG_EN
        .watchdog_err    (watchdog_err),
`endif
        .rst_            (rst_),
        .frame_start     (frame_start),
        .sphere          (sphere),
        .worker_busy     (worker_busy),
        .worker_buffer   (worker_buffer),
        .worker_activate (worker_activate),
        .worker_start_x  (worker_start_x),
        .doty            (doty),
        .pixel_y_sqrd    (pixel_y_sqrd),
        .sphere_y_sqrd   (sphere_y_sqrd),
        .worker_sphere   (worker_sphere),
        .pix_if          (pix_if),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    raytracing_row_setup #(
        .V_RES (480)
    ) u_rs (
        .clk           (clk),
        .rst_          (rst_),
        .load          (rs_load),
        .row           (rs_row),
        .sphere_y      (rs_sphere_y),
        .pixel_y_sqrd  (rs_pixel_y_sqrd),
        .doty          (rs_doty),
        .sphere_y_sqrd (rs_sphere_y_sqrd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic color_t mk_color(input int v);
        color_t c;
        c.r = 8'(v);
        c.g = 8'(v + 100);
        c.b = 8'(255 - v);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Worker model: busy one negedge after activate, for wlat+1 cycles, reset on activate low.
    initial begin
        worker_busy = '0;
        forever begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                if (worker_activate !== 1'b1) begin
                    worker_busy[w] = 1'b0;
                    wdone[w] = 1'b0;
                end else if (!wdone[w]) begin
                    if (!worker_busy[w]) begin
                        worker_busy[w] = 1'b1;
                        wcnt[w] = wlat[w];
                    end else if (wcnt[w] == 0) begin
                        worker_busy[w] = 1'b0;
                        wdone[w] = 1'b1;
                    end else begin
                        wcnt[w]--;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_count++;
        end
    end

    task automatic drain_row(input int r, input bit bp);
        int k;
        int guard;
        bit bp_done;
        k = 0;
        guard = 0;
        bp_done = 1'b0;
        while (pix_if.pix_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("row_valid_seen", 64'(pix_if.pix_valid), 64'(1));
        guard = 0;
        while (k < 6 && guard < 100) begin
            guard++;
            if (pix_if.pix_valid === 1'b1) begin
                if (bp && k == 3 && !bp_done) begin
                    pix_if.pix_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        chk("bp_valid", 64'(pix_if.pix_valid), 64'(1));
                        chk("bp_x", 64'(pix_if.pix_x), 64'(3));
                        chk("bp_color", 64'(pix_if.pix_color), 64'(mk_color(exp_v[3])));
                    end
                    pix_if.pix_ready = 1'b1;
                    bp_done = 1'b1;
                end
                chk("pix_x", 64'(pix_if.pix_x), 64'(k));
                chk("pix_y", 64'(pix_if.pix_y), 64'(r));
                chk("pix_color", 64'(pix_if.pix_color), 64'(mk_color(exp_v[k])));
                k++;
                xfers++;
            end
            @(negedge clk);
        end
        chk("row_xfers", 64'(k), 64'(6));
        chk("no_extra_pixel", 64'(pix_if.pix_valid), 64'(0));
    endtask

    initial begin
        int guard;
        rst_ = 1'b0;
        frame_start = 1'b0;
        sphere = '0;
        pix_if.pix_ready = 1'b1;
        rs_load = 1'b0;
        rs_row = '0;
        rs_sphere_y = '0;
        for (int w = 0; w < 2; w++)
            for (int j = 0; j < 3; j++)
                worker_buffer[w][j] = mk_color(10 * w + j);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_activate", 64'(worker_activate), 64'(0));
        chk("rst_valid", 64'(pix_if.pix_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_pix_x", 64'(pix_if.pix_x), 64'(0));
        chk("rst_pix_y", 64'(pix_if.pix_y), 64'(0));
        chk("rst_pixel_y_sqrd", 64'(pixel_y_sqrd), 64'(0));
        chk("rst_doty", 64'($unsigned(doty)), 64'(0));
        chk("start_x0", 64'(worker_start_x[0]), 64'(12'hFFD));
        chk("start_x1", 64'(worker_start_x[1]), 64'(12'hFFE));
        rst_ = 1'b1;

        // Row setup at full resolution: row 0 and last row
        rs_row = 9'd0;
        rs_sphere_y = 12'sd50;
        rs_load = 1'b1;
        @(negedge clk);
        chk("rs_py_sqrd_row0", 64'(rs_pixel_y_sqrd), 64'(57600));
        chk("rs_doty_row0", 64'($unsigned(rs_doty)), 64'(12000));
        chk("rs_sy_sqrd", 64'($unsigned(rs_sphere_y_sqrd)), 64'(156));
        rs_row = 9'd479;
        rs_sphere_y = -12'sd50;
        @(negedge clk);
        chk("rs_py_sqrd_row479", 64'(rs_pixel_y_sqrd), 64'(57121));
        chk("rs_doty_row479", 64'($unsigned(rs_doty)), 64'(11950));
        rs_load = 1'b0;
        rs_row = 9'd100;
        @(negedge clk);
        chk("rs_hold", 64'(rs_pixel_y_sqrd), 64'(57121));

        // Full 2-row frame
        exp_sph = '{x: 12'sd1, y: 12'sd50, z: 12'sd2, r_sqrd: 16'd3};
        sphere = exp_sph;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        sphere.y = 12'sd7;
        chk("busy_after_start", 64'(busy), 64'(1));
        @(negedge clk);
        chk("activate_on", 64'(worker_activate), 64'(1));
        chk("row0_py_sqrd", 64'(pixel_y_sqrd), 64'(1));
        chk("row0_doty", 64'($unsigned(doty)), 64'(50));
        chk("row0_sy_sqrd", 64'($unsigned(sphere_y_sqrd)), 64'(156));
        chk("sphere_latched", 64'(worker_sphere), 64'(exp_sph));
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        drain_row(0, 1'b1);
        chk("row0_busy", 64'(busy), 64'(1));
        drain_row(1, 1'b0);
        chk("frame_done_pulse", 64'(frame_done), 64'(1));
        chk("busy_cleared", 64'(busy), 64'(0));
        chk("row1_py_sqrd", 64'(pixel_y_sqrd), 64'(0));
        chk("row1_doty", 64'($unsigned(doty)), 64'(0));
        @(negedge clk);
        chk("frame_done_single", 64'(frame_done), 64'(0));
        repeat (10) @(negedge clk);
        chk("frame_done_count", 64'(fd_count), 64'(1));
        chk("total_xfers", 64'(xfers), 64'(12));
        chk("idle_after_frame", 64'(busy), 64'(0));

        // Reset in the middle of a drain
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        guard = 0;
        while (!(pix_if.pix_valid === 1'b1 && pix_if.pix_x == 10'd2) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_x", 64'(pix_if.pix_x), 64'(2));
        rst_ = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(pix_if.pix_valid), 64'(0));
        chk("midrst_activate", 64'(worker_activate), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_pix_x", 64'(pix_if.pix_x), 64'(0));
        rst_ = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_valid", 64'(pix_if.pix_valid), 64'(0));
        chk("post_rst_busy", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
